// File: rtl/multi_channel_chirp_gen.sv
// Multi-channel square-wave / linear chirp generator programmed by 6-byte
// UART command frames (SYNC, CMD, P3, P2, P1, P0).
module multi_channel_chirp_gen #(
    parameter int unsigned NUM_CH      = 10,
    parameter int unsigned CNT_W       = 32,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 25000
) (
    input  logic              CLK_25MHZ,
    input  logic              RSTN,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic [NUM_CH-1:0] CH,
    output logic              LEDR,
    output logic              o_Cmd_Ack,
    output logic              o_Frame_Err,
    output logic [NUM_CH-1:0] o_Sweep_Busy
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [3:0] OP_STOP     = 4'h0;
    localparam logic [3:0] OP_SET_HALF = 4'h1;
    localparam logic [3:0] OP_SET_STOP = 4'h2;
    localparam logic [3:0] OP_SET_STEP = 4'h3;
    localparam logic [3:0] OP_START    = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_PAY3, S_PAY2, S_PAY1, S_PAY0, S_EXEC
    } state_t;

    state_t            state;
    logic [7:0]        cmd_q;
    logic [23:0]       pay_q;
    logic [GAP_W-1:0]  gap_cnt;

    logic              frame_done;
    logic              bcast;
    logic              chan_ok;
    logic              op_ok;
    logic              cmd_valid;
    logic              apply_cmd;
    logic [3:0]        opcode;
    logic [3:0]        chan;
    logic [31:0]       pay_word;
    logic [CNT_W-1:0]  payload;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] start_bad;

    // Frame decode; the last payload byte is taken straight from the strobe
    always_comb begin
        opcode     = cmd_q[7:4];
        chan       = cmd_q[3:0];
        bcast      = (chan == 4'hF);
        chan_ok    = bcast || (32'(chan) < NUM_CH);
        op_ok      = (opcode <= OP_START);
        pay_word   = {pay_q, i_Rx_Byte};
        payload    = CNT_W'(pay_word);
        frame_done = (state == S_PAY0) && i_Rx_DV;
        cmd_valid  = chan_ok && op_ok && !((opcode == OP_START) && (|start_bad));
        apply_cmd  = frame_done && cmd_valid;
    end

    // Parser FSM with inter-byte timeout and registered ack/error pulses
    always_ff @(posedge CLK_25MHZ or negedge RSTN) begin
        if (!RSTN) begin
            state       <= S_IDLE;
            cmd_q       <= '0;
            pay_q       <= '0;
            gap_cnt     <= '0;
            o_Cmd_Ack   <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            o_Cmd_Ack   <= apply_cmd;
            o_Frame_Err <= frame_done && !cmd_valid;
            case (state)
                S_IDLE: begin
                    gap_cnt <= '0;
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state <= S_CMD;
                end
                S_EXEC: begin
                    gap_cnt <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    if (i_Rx_DV) begin
                        gap_cnt <= '0;
                        case (state)
                            S_CMD:  begin cmd_q <= i_Rx_Byte;         state <= S_PAY3; end
                            S_PAY3: begin pay_q[23:16] <= i_Rx_Byte;  state <= S_PAY2; end
                            S_PAY2: begin pay_q[15:8]  <= i_Rx_Byte;  state <= S_PAY1; end
                            S_PAY1: begin pay_q[7:0]   <= i_Rx_Byte;  state <= S_PAY0; end
                            S_PAY0: state <= S_EXEC;
                            default: state <= S_IDLE;
                        endcase
                    end else if (gap_cnt >= GAP_W'(TIMEOUT_CYC)) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
            endcase
        end
    end

    assign LEDR = CH[0];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] half_q;
        logic [CNT_W-1:0] stop_q;
        logic [CNT_W-1:0] step_q;
        logic [CNT_W-1:0] start_q;
        logic [CNT_W-1:0] cnt_q;
        logic             out_q;
        logic             sweep_q;
        logic             loop_q;
        logic             wrap;
        logic [CNT_W:0]   inc_w;
        logic [CNT_W:0]   dec_w;
        logic [CNT_W-1:0] toward;

        assign sel[gi]          = bcast || (chan == 4'(gi));
        assign start_bad[gi]    = sel[gi] && ((half_q == '0) || (step_q == '0));
        assign CH[gi]           = out_q;
        assign o_Sweep_Busy[gi] = sweep_q;

        // Half-period end detect and next sweep half, clamped at stop
        always_comb begin
            wrap  = (half_q != '0) && (cnt_q >= half_q - CNT_W'(1));
            inc_w = {1'b0, half_q} + {1'b0, step_q};
            dec_w = {1'b0, half_q} - {1'b0, step_q};
            if (half_q < stop_q) begin
                toward = (inc_w >= {1'b0, stop_q}) ? stop_q : inc_w[CNT_W-1:0];
            end else begin
                toward = (dec_w[CNT_W] || (dec_w <= {1'b0, stop_q})) ? stop_q : dec_w[CNT_W-1:0];
            end
        end

        // Channel counter/toggle, sweep stepping, and command overrides
        always_ff @(posedge CLK_25MHZ or negedge RSTN) begin
            if (!RSTN) begin
                half_q  <= '0;
                stop_q  <= '0;
                step_q  <= '0;
                start_q <= '0;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                sweep_q <= 1'b0;
                loop_q  <= 1'b0;
            end else begin
                if (half_q == '0) begin
                    cnt_q <= '0;
                    out_q <= 1'b0;
                end else if (wrap) begin
                    cnt_q <= '0;
                    out_q <= ~out_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end

                if (apply_cmd && sel[gi]) begin
                    case (opcode)
                        OP_STOP: begin
                            half_q  <= '0;
                            sweep_q <= 1'b0;
                            cnt_q   <= '0;
                            out_q   <= 1'b0;
                        end
                        OP_SET_HALF: begin
                            half_q  <= payload;
                            sweep_q <= 1'b0;
                            cnt_q   <= '0;
                            out_q   <= out_q;
                        end
                        OP_SET_STOP: stop_q <= payload;
                        OP_SET_STEP: step_q <= payload;
                        OP_START: begin
                            start_q <= half_q;
                            loop_q  <= payload[0];
                            sweep_q <= !((half_q == stop_q) && !payload[0]);
                        end
                        default: ;
                    endcase
                end else if (wrap && !out_q && sweep_q) begin
                    if (half_q == stop_q) begin
                        if (loop_q) half_q <= start_q;
                        else        sweep_q <= 1'b0;
                    end else begin
                        half_q <= toward;
                        if ((toward == stop_q) && !loop_q) sweep_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_chirp_gen.sv
// Directed scoreboard bench for multi_channel_chirp_gen (default parameters).
module tb_multi_channel_chirp_gen;

    localparam int unsigned NUM_CH = 10;
    localparam logic [7:0]  SYNC   = 8'hA5;

    localparam logic [3:0] OP_STOP     = 4'h0;
    localparam logic [3:0] OP_SET_HALF = 4'h1;
    localparam logic [3:0] OP_SET_STOP = 4'h2;
    localparam logic [3:0] OP_SET_STEP = 4'h3;
    localparam logic [3:0] OP_START    = 4'h4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              dv;
    logic [7:0]        rx_byte;
    logic [NUM_CH-1:0] ch;
    logic              ledr;
    logic              ack;
    logic              ferr;
    logic [NUM_CH-1:0] busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    typedef struct {
        int   dur;
        logic lvl;
        logic bsy;
    } phase_t;

    phase_t     ph_q[$];
    logic [1:0] sb_q[$];

    always #20 clk = ~clk;

    multi_channel_chirp_gen dut (
        .CLK_25MHZ    (clk),
        .RSTN         (rstn),
        .i_Rx_DV      (dv),
        .i_Rx_Byte    (rx_byte),
        .CH           (ch),
        .LEDR         (ledr),
        .o_Cmd_Ack    (ack),
        .o_Frame_Err  (ferr),
        .o_Sweep_Busy (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        dv      = 1'b1;
        rx_byte = b;
        @(negedge clk);
        dv      = 1'b0;
    endtask

    // Full frame after one idle cycle; returns at the EXEC-cycle sample point
    task automatic send_frame(input logic [3:0] op, input logic [3:0] chn, input logic [31:0] p,
                              input logic exp_ack, input logic exp_err, input string tag);
        logic [1:0] e;
        sb_q.push_back({exp_ack, exp_err});
        @(negedge clk);
        send_byte(SYNC);
        send_byte({op, chn});
        send_byte(p[31:24]);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
        e = sb_q.pop_front();
        check({tag, " ack"}, 64'(ack), 64'(e[1]));
        check({tag, " err"}, 64'(ferr), 64'(e[0]));
    endtask

    task automatic wait_toggle(input int idx, output int n);
        logic prev;
        prev = ch[idx];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ch[idx] === prev) && (n < 200));
    endtask

    task automatic wait_rise(input int idx);
        int n;
        wait_toggle(idx, n);
        if (ch[idx] !== 1'b1) wait_toggle(idx, n);
    endtask

    task automatic push_ph(input int d, input logic l, input logic b);
        phase_t e;
        e.dur = d;
        e.lvl = l;
        e.bsy = b;
        ph_q.push_back(e);
    endtask

    task automatic run_phases(input int idx, input string tag);
        phase_t e;
        int     n;
        while (ph_q.size() > 0) begin
            e = ph_q.pop_front();
            wait_toggle(idx, n);
            check({tag, " dur"},  64'(n),         64'(e.dur));
            check({tag, " lvl"},  64'(ch[idx]),   64'(e.lvl));
            check({tag, " busy"}, 64'(busy[idx]), 64'(e.bsy));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;

        rstn = 1'b0; dv = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("reset CH",   64'(ch),   64'(0));
        check("reset LEDR", 64'(ledr), 64'(0));
        check("reset ack",  64'(ack),  64'(0));
        check("reset err",  64'(ferr), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        rstn = 1'b1;
        @(negedge clk);

        // ch0 half=5: first toggle 5 cycles after EXEC, then every 5
        send_frame(OP_SET_HALF, 4'd0, 32'd5, 1'b1, 1'b0, "t1 set_half");
        check("t1 exec CH", 64'(ch), 64'(0));
        push_ph(5, 1'b1, 1'b0);
        push_ph(5, 1'b0, 1'b0);
        push_ph(5, 1'b1, 1'b0);
        run_phases(0, "t1 ch0");
        check("t1 LEDR", 64'(ledr), 64'(1));
        check("t1 others", 64'(ch[9:1]), 64'(0));

        // Broadcast half=3, then STOP ch2
        send_frame(OP_SET_HALF, 4'hF, 32'd3, 1'b1, 1'b0, "t2 bcast");
        send_frame(OP_STOP, 4'd2, 32'd0, 1'b1, 1'b0, "t2 stop ch2");
        check("t2 ch2 at exec", 64'(ch[2]), 64'(0));
        push_ph(2, 1'b1, 1'b0);
        push_ph(3, 1'b0, 1'b0);
        push_ph(3, 1'b1, 1'b0);
        run_phases(5, "t2 ch5");
        check("t2 ch2 held", 64'(ch[2]), 64'(0));
        send_frame(OP_STOP, 4'hF, 32'd0, 1'b1, 1'b0, "t2 stop all");
        check("t2 all stopped", 64'(ch), 64'(0));

        // ch1 sweep 10 -> 4 step 3, no loop
        send_frame(OP_SET_HALF, 4'd1, 32'd10, 1'b1, 1'b0, "t3 half");
        send_frame(OP_SET_STOP, 4'd1, 32'd4,  1'b1, 1'b0, "t3 stop");
        send_frame(OP_SET_STEP, 4'd1, 32'd3,  1'b1, 1'b0, "t3 step");
        wait_rise(1);
        send_frame(OP_START, 4'd1, 32'd0, 1'b1, 1'b0, "t3 start");
        check("t3 busy at exec", 64'(busy), 64'h2);
        push_ph(3,  1'b0, 1'b1);
        push_ph(10, 1'b1, 1'b1);
        push_ph(7,  1'b0, 1'b1);
        push_ph(7,  1'b1, 1'b0);
        push_ph(4,  1'b0, 1'b0);
        push_ph(4,  1'b1, 1'b0);
        push_ph(4,  1'b0, 1'b0);
        run_phases(1, "t3 ch1");

        // Same sweep with loop=1
        send_frame(OP_SET_HALF, 4'd1, 32'd10, 1'b1, 1'b0, "t4 half");
        check("t4 busy cleared", 64'(busy[1]), 64'(0));
        wait_rise(1);
        send_frame(OP_START, 4'd1, 32'd1, 1'b1, 1'b0, "t4 start loop");
        push_ph(3,  1'b0, 1'b1);
        push_ph(10, 1'b1, 1'b1);
        push_ph(7,  1'b0, 1'b1);
        push_ph(7,  1'b1, 1'b1);
        push_ph(4,  1'b0, 1'b1);
        push_ph(4,  1'b1, 1'b1);
        push_ph(10, 1'b0, 1'b1);
        push_ph(10, 1'b1, 1'b1);
        push_ph(7,  1'b0, 1'b1);
        push_ph(7,  1'b1, 1'b1);
        run_phases(1, "t4 ch1");

        // Rejected frames leave state untouched
        send_frame(4'h7, 4'd0, 32'd9, 1'b0, 1'b1, "t5 bad op");
        check("t5 ch0 unchanged", 64'(ch[0]), 64'(0));
        check("t5 busy unchanged", 64'(busy), 64'h2);
        send_frame(OP_SET_HALF, 4'd12, 32'd5, 1'b0, 1'b1, "t5 bad ch");
        check("t5 ch9..4 unchanged", 64'(ch[9:4]), 64'(0));
        send_frame(OP_SET_HALF, 4'd3, 32'd6, 1'b1, 1'b0, "t5 ch3 half");
        send_frame(OP_START, 4'd3, 32'd0, 1'b0, 1'b1, "t5 start step0");
        check("t5 busy after reject", 64'(busy), 64'h2);
        send_frame(OP_STOP, 4'hF, 32'd0, 1'b1, 1'b0, "t5 stop all");

        // Partial frame abandoned by timeout, then a valid frame
        @(negedge clk);
        send_byte(SYNC);
        send_byte({OP_SET_HALF, 4'd4});
        send_byte(8'h00);
        seen = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            seen = seen | ferr | ack;
        end
        check("t6 no pulse in gap", 64'(seen), 64'(0));
        send_frame(OP_SET_HALF, 4'd4, 32'd2, 1'b1, 1'b0, "t6 after gap");
        wait_toggle(4, n);
        check("t6 ch4 first toggle", 64'(n), 64'(2));

        // Asynchronous reset mid-frame
        @(negedge clk);
        send_byte(SYNC);
        send_byte({OP_SET_HALF, 4'd0});
        #3 rstn = 1'b0;
        #1;
        check("t7 rst CH",   64'(ch),   64'(0));
        check("t7 rst LEDR", 64'(ledr), 64'(0));
        check("t7 rst ack",  64'(ack),  64'(0));
        check("t7 rst err",  64'(ferr), 64'(0));
        check("t7 rst busy", 64'(busy), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h05);
        check("t7 tail ack", 64'(ack),  64'(0));
        check("t7 tail err", 64'(ferr), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t7 CH idle", 64'(ch), 64'(0));
        end
        send_frame(OP_SET_HALF, 4'd0, 32'd1, 1'b1, 1'b0, "t7 fresh frame");
        wait_toggle(0, n);
        check("t7 ch0 toggle", 64'(n), 64'(1));
        check("t7 LEDR", 64'(ledr), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_channel_chirp_gen.md
# multi_channel_chirp_gen

- Parametrised, multi-channel square-wave and chirp generator, driven by command frames from the host over UART.
- Consumes the byte stream of the existing uart_rx (one byte per o_Rx_DV pulse) and parses 6-byte frames.
- Per channel, it programs a fixed half-period or a linear half-period sweep (chirp), then toggles one output bit per channel on CH.
- Sits between uart_rx and the CH/LEDR pins of the top level.

## Interface

Parameters:
- NUM_CH, default 10: number of output channels, 1..15.
- CNT_W, default 32: width of half-period, stop, step and counter registers.
- SYNC_BYTE, default 8'hA5: frame start marker.
- TIMEOUT_CYC, default 25000: maximum inter-byte gap inside a frame, in clock cycles (1 ms at 25 MHz).

Ports:
- CLK_25MHZ, in, 1: single system clock.
- RSTN, in, 1: asynchronous, active-low reset.
- i_Rx_DV, in, 1: one-cycle strobe; i_Rx_Byte is valid.
- i_Rx_Byte, in, 8: received byte.
- CH, out, NUM_CH: channel outputs.
- LEDR, out, 1: mirror of CH[0].
- o_Cmd_Ack, out, 1: one-cycle pulse when a valid frame is applied.
- o_Frame_Err, out, 1: one-cycle pulse when a frame is rejected.
- o_Sweep_Busy, out, NUM_CH: per-channel sweep active.

## Operation

Frame format: SYNC_BYTE, CMD, P3, P2, P1, P0.
- CMD[7:4] is the opcode; CMD[3:0] is the channel.
- Payload P = {P3,P2,P1,P0}, MSB first, truncated to CNT_W.
- Channel 4'hF means broadcast to all channels.

Parser FSM: IDLE -> CMD -> PAY3 -> PAY2 -> PAY1 -> PAY0 -> EXEC -> IDLE.
- In IDLE, any non-SYNC byte is ignored.
- Each state advances on i_Rx_DV.
- An inter-byte gap longer than TIMEOUT_CYC in states CMD..PAY0 returns the FSM to IDLE silently, with no error pulse.
- EXEC lasts one cycle, then returns to IDLE.

Opcodes:
- 0x0 STOP: half=0, sweep off, counter=0, CH bit forced to 0.
- 0x1 SET_HALF: half=P, sweep off, counter=0. The CH level is kept.
- 0x2 SET_STOP: stop=P. No effect on the running output.
- 0x3 SET_STEP: step=P.
- 0x4 START_SWEEP: start=half, sweep on; P[0] is the loop flag.
  - Rejected if half==0 or step==0.

Rejection:
- Any other opcode, or a channel >= NUM_CH other than 4'hF, raises o_Frame_Err.
- A rejected frame changes no channel state.

Channel behaviour (each channel independent):
- half==0 means idle: the output is held at 0 and the counter is held at 0.
- half>=1: the counter counts 0..half-1. At half-1 the output toggles and the counter returns to 0. Output period = 2*half cycles.
- Sweep: on each output 0->1 toggle while sweeping:
  - If half<stop: half = min(half+step, stop).
  - If half>stop: half = max(half-step, stop).
  - Arithmetic uses CNT_W+1 bits, so there is no wrap-around.
- When half==stop after an update (or already at START_SWEEP):
  - loop=0: sweep off; the channel keeps running at stop.
  - loop=1: half reloads from start on the next 0->1 toggle.
- o_Sweep_Busy[i] = sweep on for channel i.

## Timing

Reset values: CH=0, LEDR=0, o_Cmd_Ack=0, o_Frame_Err=0, o_Sweep_Busy=0. All half/stop/step/start/counters = 0. Parser = IDLE.

Latency:
- The EXEC cycle follows the i_Rx_DV of P0.
- Channel registers update and o_Cmd_Ack pulses in EXEC, one cycle after P0's strobe.
- o_Frame_Err pulses in EXEC in place of o_Cmd_Ack.
- After SET_HALF, the first toggle occurs exactly `half` cycles after EXEC.

Output timing:
- LEDR equals CH[0] in every cycle (combinational from the same flop).
- All outputs are registered.

Collisions:
- A command and a sweep update hitting the same channel in the same cycle: the command wins and the sweep update is dropped.
- An i_Rx_DV arriving during EXEC is ignored.
- Reset asserted mid-frame or mid-sweep returns everything to reset values asynchronously; the next frame needs a fresh SYNC.

## Test plan

- Reset, then SET_HALF ch0 P=5 -> o_Cmd_Ack one cycle after the last byte; CH[0]/LEDR toggle every 5 cycles (period 10); other channels stay 0.
- Broadcast SET_HALF ch F P=3, then STOP ch2 -> all channels toggle every 3 cycles except CH[2], which is 0 from the STOP's EXEC cycle onward.
- ch1 SET_HALF 10, SET_STOP 4, SET_STEP 3, START_SWEEP loop=0 -> successive half-periods 10,7,4,4...; o_Sweep_Busy[1] falls when 4 is reached.
- Same sweep with loop=1 -> half sequence 10,7,4,10,7,4; busy stays 1.
- Bad opcode 0x7, channel 12 with NUM_CH=10, and START_SWEEP with step 0 -> o_Frame_Err pulses each time; outputs unchanged.
- Send SYNC, CMD, P3, then a gap of 25001 cycles, then a full valid frame -> the partial frame is discarded with no error; the valid frame is acked. RSTN low mid-frame -> all outputs 0, parser in IDLE.
